// File: rtl/rom_responder_pkg.sv
// Shared constants, state encoding and address checking for the instruction-memory responder.
package rom_responder_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0

    // Wide enough for the largest legal LATENCY of 15.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // The whole word index is compared so high addresses never alias onto low words.
    function automatic logic addr_err(input logic [XLEN-1:0] addr, input int unsigned depth);
        logic [XLEN-1:0] word_idx;
        word_idx = {2'b00, addr[XLEN-1:2]};
        return (addr[1:0] != 2'b00) || (word_idx >= depth);
    endfunction

endpackage

// File: rtl/rom_responder_wait_counter.sv
// Wait-state down-counter: load, decrement toward zero, synchronous clear.
module rom_responder_wait_counter
    import rom_responder_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rom_responder.sv
// Instruction-memory responder: valid/ready fetch requests, configurable wait states,
// registered response with backpressure and a redirect flush.
module rom_responder
    import rom_responder_pkg::*;
#(
    parameter int unsigned     DEPTH              = 32,
    parameter int unsigned     LATENCY            = 2,
    parameter logic [XLEN-1:0] NOP                = INST_NOP,
    parameter logic [XLEN-1:0] MEM_INIT [DEPTH]   = '{default: '0}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    input  logic            flush
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    logic [XLEN-1:0] data [DEPTH];
    assign data = MEM_INIT;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic             err_q;
    logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             accept;
    logic             rsp_hs;
    logic             req_err;
    logic             cnt_load, cnt_dec, cnt_clr, cnt_zero;
    logic             load_rsp;
    logic [IDX_W-1:0] lookup_idx;
    logic             lookup_err;

    assign rsp_valid = (state_q == StResp);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_hs    = rsp_valid && rsp_ready;
    assign req_err   = addr_err(req_addr, DEPTH);

    // Held low during reset and flush so nothing is accepted across either.
    always_comb begin
        req_ready = 1'b0;
        if (rst && !flush) begin
            case (state_q)
                StIdle:  req_ready = 1'b1;
                StResp:  req_ready = rsp_ready;
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_d  = (LATENCY == 0) ? StResp : StWait;
                        cnt_load = (LATENCY != 0);
                    end
                end
                StWait: begin
                    if (cnt_zero) begin
                        state_d = StResp;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_hs) begin
                        if (accept) begin
                            state_d  = (LATENCY == 0) ? StResp : StWait;
                            cnt_load = (LATENCY != 0);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // With zero latency the word is fetched straight from the incoming request.
    assign lookup_idx = accept ? req_addr[2 +: IDX_W] : idx_q;
    assign lookup_err = accept ? req_err : err_q;
    assign load_rsp   = (state_d == StResp) && ((state_q != StResp) || rsp_hs);

    always_comb begin
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (load_rsp) begin
            rsp_data_d = lookup_err ? NOP : data[lookup_idx];
            rsp_err_d  = lookup_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            if (accept) begin
                idx_q <= req_addr[2 +: IDX_W];
                err_q <= req_err;
            end
        end
    end

    rom_responder_wait_counter u_wait_counter (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (CNT_INIT),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

endmodule

// File: doc/rom_responder.md
Name: rom_responder

Overview:
Instruction-memory responder: the memory side of the fetch interface that the ifu drives. It accepts word fetch requests on a valid/ready handshake and inserts a configurable number of wait states. It returns instruction words on a valid/ready response channel with backpressure. A flush input lets the fetch side cancel an in-flight request on redirect. It replaces the zero-latency rom so the ifu and the pipeline can be exercised against realistic memory timing.

Parameters:
DEPTH, 32, number of 32-bit words; byte-address range is 0 .. 4*DEPTH-1
LATENCY, 2, wait cycles between request acceptance and response valid; legal range 0..15
NOP, 32'h00000013, word returned on an error response (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  1  fetch request present
req_ready  out  1  responder can accept a request this cycle
req_addr  in  `XLEN_WIDTH  byte address of the instruction
rsp_valid  out  1  response word valid
rsp_ready  in  1  fetch side accepts the response
rsp_data  out  `XLEN_WIDTH  instruction word
rsp_err  out  1  response is for a misaligned or out-of-range address
flush  in  1  cancel the in-flight request and any pending response

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, req_ready=0 while rst is asserted, rsp_valid=0, rsp_data=0, rsp_err=0, wait counter=0. Memory contents are not cleared. The bench preloads the memory array `data` with $readmemh.
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. When req_valid&&!flush, latch the address and compute err = (addr[1:0]!=0) || (addr>>2 >= DEPTH).
  - If LATENCY==0, go to RESP next cycle.
  - Otherwise load the counter with LATENCY-1 and go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle. When the counter is 0, go to RESP.
- Response contents: on entry to RESP, rsp_data = err ? NOP : data[addr>>2] and rsp_err = err, both registered. Total latency from the accept edge to rsp_valid=1 is LATENCY+1 cycles.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until the handshake (rsp_valid&&rsp_ready).
  - req_ready = rsp_ready, so back-to-back fetches are possible.
  - On the handshake with req_valid also high, the new request is accepted in the same cycle and the next state is WAIT, or RESP when LATENCY==0. Otherwise the next state is IDLE.
- flush (synchronous, highest priority below reset): from any state, the next state is IDLE. rsp_valid drops the next cycle and the counter clears.
  - A request presented in the same cycle as flush is not accepted; req_ready is forced to 0 while flush=1.
  - A response handshake occurring in the same cycle as flush still counts for the fetch side. The responder only guarantees that no further response is produced for the flushed request.
- Only one request is outstanding at a time; there is no queueing beyond the single latched address.
- Address arithmetic: the word index is addr[`XLEN-1:2]. The range check compares the full index against DEPTH, so no aliasing or wrap-around occurs.
- If rst is asserted mid-transaction, the response is lost and the responder returns to IDLE with no rsp_valid glitch after release.

Decomposition:
- `XLEN_WIDTH, `XLEN and the NOP encoding come from define/const.v and define/inst.v; add `INST_NOP there if it is not already present.
- State encodings are local parameters of this module.
- An optional sub-module, wait_counter (load/decrement/zero flag), keeps the FSM clean. Otherwise the design is a single module.

Test Plan:
- Basic fetch: LATENCY=2, data[1]=32'h00500093; req addr=4 accepted at cycle t -> rsp_valid=1 at t+3 with rsp_data=32'h00500093 and rsp_err=0.
- Backpressure: rsp_ready=0 for 4 cycles -> rsp_valid stays 1 and rsp_data is unchanged; req_ready=0 throughout; rsp_ready=1 -> handshake, then state IDLE.
- Back-to-back: LATENCY=0, continuous req_valid at addr 0,4,8,12 with rsp_ready=1 -> one response per cycle, words data[0..3] in order, no bubbles after the first.
- Errors: addr=6 -> rsp_data=32'h00000013, rsp_err=1; addr=4*DEPTH -> rsp_err=1; addr=4*DEPTH-4 -> rsp_err=0 and the last word is returned.
- Flush: flush asserted during WAIT -> no rsp_valid for that request; a new request at addr 8 the next cycle returns data[2] after LATENCY+1 cycles.
- Async reset: assert rst=0 mid-WAIT between clock edges -> rsp_valid=0 immediately; after release, the first request behaves as in scenario 1.
